// File: rtl/seq_div12x6_if.sv
// Handshake and result bus between a requester and the sequential divider.
interface seq_div12x6_if #(
  parameter int DW = 12,
  parameter int VW = 6
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          ovf;
  logic          exact;
  logic          dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, exact, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf, exact, dbz
  );
endinterface

// File: rtl/seq_div12x6.sv
// Sequential restoring divider, one quotient bit per clock. Recovers the
// other factor of a 6x6 product and flags whether the factorisation is exact.
module seq_div12x6 #(
  parameter int DW = 12,
  parameter int VW = 6
) (
  input  logic clk,
  input  logic rst_n,
  seq_div12x6_if.slave bus
);
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, next_state;
  logic [DW-1:0] d_work;
  logic [DW-1:0] q_work;
  logic [VW-1:0] div_reg;
  logic [VW:0]   r_work;
  logic [CW-1:0] cnt;
  logic          dbz_work;
  logic [VW:0]   r_shift;
  logic [VW:0]   r_next;
  logic          qbit;
  logic          accept;
  logic          q_high;

  assign accept   = (state == IDLE) && bus.start;
  assign bus.busy = (state != IDLE);
  assign q_high   = |q_work[DW-1:VW];

  // State register; reset aborts any division in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; a zero divisor skips the iterations entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = (bus.divisor == '0) ? DONE : CALC;
      CALC: if (cnt == LAST) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift = {r_work[VW-1:0], d_work[DW-1]};
    r_next  = r_shift;
    qbit    = 1'b0;
    if (r_shift >= {1'b0, div_reg}) begin
      r_next = r_shift - {1'b0, div_reg};
      qbit   = 1'b1;
    end
  end

  // Working registers and published results; results change only on accept
  // (cleared) and when leaving DONE (loaded together with the done pulse).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.ovf       <= 1'b0;
      bus.exact     <= 1'b0;
      bus.dbz       <= 1'b0;
    end else begin
      bus.done <= (state == DONE);
      if (accept) begin
        d_work        <= bus.dividend;
        div_reg       <= bus.divisor;
        cnt           <= '0;
        r_work        <= '0;
        q_work        <= '0;
        dbz_work      <= (bus.divisor == '0);
        bus.quotient  <= '0;
        bus.remainder <= '0;
        bus.ovf       <= 1'b0;
        bus.exact     <= 1'b0;
        bus.dbz       <= 1'b0;
      end else if (state == CALC) begin
        r_work <= r_next;
        d_work <= {d_work[DW-2:0], 1'b0};
        q_work <= {q_work[DW-2:0], qbit};
        cnt    <= cnt + 1'b1;
      end else if (state == DONE) begin
        if (dbz_work) begin
          bus.quotient  <= '1;
          bus.remainder <= d_work[VW-1:0];
          bus.ovf       <= 1'b1;
          bus.exact     <= 1'b0;
          bus.dbz       <= 1'b1;
        end else begin
          bus.quotient  <= q_work;
          bus.remainder <= r_work[VW-1:0];
          bus.ovf       <= q_high;
          bus.exact     <= (r_work == '0) && !q_high;
          bus.dbz       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_div12x6.sv
// Directed bench for the sequential 12/6 divider.
module tb_seq_div12x6;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   lat;
  int   dones;
  int   done_at;
  logic [11:0] q_seen;

  seq_div12x6_if #(.DW(12), .VW(6)) bus ();

  seq_div12x6 #(.DW(12), .VW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [11:0] p, input logic [5:0] b);
    @(negedge clk);
    bus.dividend = p;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
    end
  endtask

  task automatic check_result(input string tag, input logic [11:0] q, input logic [5:0] r,
                              input logic o, input logic e, input logic z);
    check({tag, "_q"},     bus.quotient,  q);
    check({tag, "_r"},     bus.remainder, r);
    check({tag, "_ovf"},   bus.ovf,       o);
    check({tag, "_exact"}, bus.exact,     e);
    check({tag, "_dbz"},   bus.dbz,       z);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check_result("rst", 12'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 2491 / 47 = 53 exactly, fits 6 bits
    start_op(12'd2491, 6'd47);
    check("op1_busy", bus.busy, 1);
    wait_done(lat);
    check("op1_lat", lat, 13);
    check_result("op1", 12'd53, 6'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("op1_done_pulse", bus.done, 0);
    check("op1_hold_q", bus.quotient, 53);
    check("op1_idle_busy", bus.busy, 0);

    // 4095 / 63 = 65, quotient too wide
    start_op(12'd4095, 6'd63);
    check("op2_clear_q", bus.quotient, 0);
    wait_done(lat);
    check("op2_lat", lat, 13);
    check_result("op2", 12'd65, 6'd0, 1'b1, 1'b0, 1'b0);

    // divide by zero: skips iterations
    start_op(12'd100, 6'd0);
    wait_done(lat);
    check("dbz_lat", lat, 1);
    check_result("dbz", 12'hFFF, 6'd36, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("dbz_done_pulse", bus.done, 0);

    // zero dividend
    start_op(12'd0, 6'd5);
    wait_done(lat);
    check("zero_lat", lat, 13);
    check_result("zero", 12'd0, 6'd0, 1'b0, 1'b1, 1'b0);

    // 2000 / 7 = 285 rem 5
    start_op(12'd2000, 6'd7);
    wait_done(lat);
    check("op5_lat", lat, 13);
    check_result("op5", 12'd285, 6'd5, 1'b1, 1'b0, 1'b0);

    // start pulses during CALC and DONE must be ignored
    start_op(12'd2491, 6'd47);
    dones   = 0;
    done_at = 0;
    q_seen  = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        done_at = i;
        q_seen  = bus.quotient;
      end
      if (i == 12) check("ign_busy_done_state", bus.busy, 1);
      if (i == 5 || i == 12) begin
        bus.dividend = 12'd1;
        bus.divisor  = 6'd1;
        bus.start    = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("ign_dones", dones, 1);
    check("ign_done_at", done_at, 13);
    check("ign_q_at_done", q_seen, 53);
    check("ign_q_hold", bus.quotient, 53);
    check("ign_r_hold", bus.remainder, 0);

    // reset during iteration 6 aborts the division
    start_op(12'd3969, 6'd63);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check_result("abort", 12'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);

    // restart after abort: 3969 / 63 = 63 exactly
    start_op(12'd3969, 6'd63);
    wait_done(lat);
    check("restart_lat", lat, 13);
    check_result("restart", 12'd63, 6'd0, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
